crypto_key_sequencer: RTL and testbench
=======================================

# crypto_key_sequencer

Sequencer that moves key material from the on-chip key store into the key registers of the crypto peripherals (AES0, AES1, AES2, HMAC) in the `0xfff52xxxxx` region. A requester names a target engine, a key slot and a key-store index. The block then reads the key words one by one and writes each to the engine's register address over the peripheral register bus. It sits between the key-store read port and the crypto register bus, so software never has to handle raw key words.

## Interface
Parameters:
- `AddrWidth`, 64, register-bus address width
- `DataWidth`, 32, key word width (one register per word)
- `KsAddrWidth`, 8, key-store word address width

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `load_req_i`  in  1  load request
- `load_gnt_o`  out  1  request accepted, i.e. `load_req_i` while IDLE (combinational)
- `target_i`  in  2  target engine: 0=AES0, 1=AES1, 2=AES2, 3=HMAC
- `slot_i`  in  2  key slot within the target
- `ks_index_i`  in  KsAddrWidth  key-store address of word 0
- `abort_i`  in  1  abandon the current load
- `busy_o`  out  1  high whenever the FSM is not IDLE
- `done_o`  out  1  1-cycle pulse when a load completes
- `err_o`  out  1  1-cycle pulse for an invalid target/slot pair, or on abort
- `ks_req_o`  out  1  key-store read strobe, 1 cycle
- `ks_addr_o`  out  KsAddrWidth  key-store read address
- `ks_rvalid_i`  in  1  read data valid; arrives 1 or more cycles after `ks_req_o`
- `ks_rdata_i`  in  DataWidth  read data
- `bus_req_o`  out  1  register-bus write request
- `bus_we_o`  out  1  constant 1
- `bus_addr_o`  out  AddrWidth  write address
- `bus_wdata_o`  out  DataWidth  write data
- `bus_gnt_i`  in  1  write accepted

## Operation
- Slot map: word address = Base + 8*(offset + idx).
  - AES0: offsets {5, 20, 26}, 6 words.
  - AES1: offsets {16, 32, 48}, 8 words.
  - AES2: offsets {5, 18, 22}, 4 words.
  - HMAC: offset {26} for slot 0 only, 8 words.
- Slot 3, and HMAC slots 1–3, are invalid.
- FSM states: IDLE, READ, WAIT_RD, WRITE, DONE.
- IDLE
  - On `load_req_i`: latch target, slot, index and word count; clear `idx`.
  - Invalid pair: pulse `err_o` and stay in IDLE.
  - Valid pair: go to READ.
- READ: assert `ks_req_o` with `ks_addr_o` = index+idx; go to WAIT_RD.
- WAIT_RD: on `ks_rvalid_i`, capture the data and go to WRITE.
- WRITE
  - Hold `bus_req_o`, address and data stable until `bus_gnt_i`.
  - On grant: zero the data register and increment `idx`.
  - If `idx` was the last word, go to DONE; otherwise go to READ.
- DONE: pulse `done_o`, then go to IDLE.
- `abort_i` in any non-IDLE state:
  - Next state is IDLE; pulse `err_o`; zero the data register.
  - If in WRITE, drop `bus_req_o` at the next edge. The register bus tolerates a withdrawn request.
  - A late `ks_rvalid_i` after an abort is ignored.
- Address arithmetic is done in AddrWidth bits with no wrap. Key-store address wraps modulo 2^KsAddrWidth.
- Exactly one key-store read is outstanding at a time. `ks_rvalid_i` outside WAIT_RD is ignored.

## Timing
- Reset values: `load_gnt_o` 0, `busy_o` 0, `done_o` 0, `err_o` 0, `ks_req_o` 0, `ks_addr_o` 0, `bus_req_o` 0, `bus_addr_o` 0, `bus_wdata_o` 0, `bus_we_o` 1.
- Reset mid-load returns to IDLE immediately and clears the data register.
- Per-word minimum is 3 cycles, given 1-cycle read latency and grant in the first WRITE cycle.
- Load latency from grant to `done_o` is 3N+1 cycles minimum, where N is the word count.
- `load_gnt_o` is low while busy. A new request is taken at the earliest in the cycle after `done_o`.
- Simultaneous `abort_i` and `bus_gnt_i`: the abort wins. The granted write counts as issued, but `done_o` does not pulse.

## Structure
- Shared package `crypto_key_seq_pkg`:
  - Target enum.
  - Per-target base address, slot offset array, word count and valid-slot mask.
  - Base/offset values are derived from the SoC crypto base constants.
- Sub-module `key_slot_decode`: combinational map from target/slot to {base address, word count, valid}.

## Test plan
- AES0 slot 1, index 0x10, read latency 1, immediate grant:
  - 6 writes at `0xfff52000A0`..`0xfff52000C8`, step 8, data = store[0x10..0x15].
  - `done_o` 19 cycles after grant.
- AES1 slot 2, with `bus_gnt_i` delayed 4 cycles per word:
  - 8 writes at `0xfff5201180`..`0xfff52011B8`.
  - Address and data stay stable while ungranted.
- HMAC slot 0: writes at `0xfff52030D0`..`0xfff5203108`. HMAC slot 1: `err_o` pulse, no bus or key-store activity.
- AES2 slot 0, index 0xFE: addresses `0xfff5209028`..`0xfff5209040`, key-store addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
- `abort_i` during the third WRITE of an AES0 load:
  - `err_o` pulses and `bus_req_o` drops next cycle; no `done_o`; `bus_wdata_o` reads 0.
  - Next request is granted in IDLE.
- Assert `rst_ni` in WAIT_RD, then release; return `ks_rvalid_i` late: all outputs at reset values, the late data is ignored.

Source files
------------

// File: rtl/crypto_key_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crypto_key_seq_pkg
// Purpose  : Shared types and crypto-region slot map for the key sequencer.
// Revision : 1.0
// ============================================================================
package crypto_key_seq_pkg;

  typedef enum logic [1:0] {
    TGT_AES0 = 2'd0,
    TGT_AES1 = 2'd1,
    TGT_AES2 = 2'd2,
    TGT_HMAC = 2'd3
  } target_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [63:0] SOC_CRYPTO_BASE = 64'h0000_00ff_f520_0000;

  // Engine register windows inside the crypto region, indexed by target_e.
  localparam logic [3:0][63:0] ENGINE_BASE = {
    SOC_CRYPTO_BASE + 64'h3000,   // HMAC
    SOC_CRYPTO_BASE + 64'h9000,   // AES2
    SOC_CRYPTO_BASE + 64'h1000,   // AES1
    SOC_CRYPTO_BASE + 64'h0000    // AES0
  };

  // Slot offsets in register (8-byte) units, indexed [target][slot].
  localparam logic [3:0][2:0][7:0] SLOT_OFFSET = {
    {8'd0,  8'd0,  8'd26},
    {8'd22, 8'd18, 8'd5},
    {8'd48, 8'd32, 8'd16},
    {8'd26, 8'd20, 8'd5}
  };

  localparam logic [3:0][3:0] WORD_COUNT = {4'd8, 4'd4, 4'd8, 4'd6};

  localparam logic [3:0][3:0] VALID_SLOT_MASK = {4'b0001, 4'b0111, 4'b0111, 4'b0111};

endpackage
`default_nettype wire

// File: rtl/key_slot_decode.sv
`default_nettype none
// ============================================================================
// Module   : key_slot_decode
// Purpose  : Maps target/slot to key register base address, word count, valid.
// Revision : 1.0
// ============================================================================
module key_slot_decode
  import crypto_key_seq_pkg::*;
#(
  parameter int AddrWidth = 64
) (
  input  logic [1:0]           target_i,
  input  logic [1:0]           slot_i,
  output logic [AddrWidth-1:0] base_addr_o,
  output logic [3:0]           word_count_o,
  output logic                 valid_o
);

  logic [1:0]  w_slot_idx;
  logic [7:0]  w_offset;
  logic [63:0] w_addr_full;

  // Slot 3 has no offset entry; its decode is discarded via valid_o anyway.
  always_comb begin
    w_slot_idx  = (slot_i == 2'd3) ? 2'd0 : slot_i;
    w_offset    = SLOT_OFFSET[target_i][w_slot_idx];
    w_addr_full = ENGINE_BASE[target_i] + {53'd0, w_offset, 3'd0};
  end

  assign base_addr_o  = AddrWidth'(w_addr_full);
  assign word_count_o = WORD_COUNT[target_i];
  assign valid_o      = VALID_SLOT_MASK[target_i][slot_i];

endmodule
`default_nettype wire

// File: rtl/crypto_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : crypto_key_sequencer
// Purpose  : Copies key words from the key store into crypto engine registers.
// Revision : 1.0
// ============================================================================
module crypto_key_sequencer
  import crypto_key_seq_pkg::*;
#(
  parameter int AddrWidth   = 64,
  parameter int DataWidth   = 32,
  parameter int KsAddrWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_req_i,
  output logic                   load_gnt_o,
  input  logic [1:0]             target_i,
  input  logic [1:0]             slot_i,
  input  logic [KsAddrWidth-1:0] ks_index_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   ks_req_o,
  output logic [KsAddrWidth-1:0] ks_addr_o,
  input  logic                   ks_rvalid_i,
  input  logic [DataWidth-1:0]   ks_rdata_i,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [AddrWidth-1:0]   bus_addr_o,
  output logic [DataWidth-1:0]   bus_wdata_o,
  input  logic                   bus_gnt_i
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [AddrWidth-1:0]   r_base;
  logic [3:0]             r_count;
  logic [3:0]             r_idx;
  logic [KsAddrWidth-1:0] r_index;
  logic [DataWidth-1:0]   r_data;
  logic                   r_err;

  logic [AddrWidth-1:0]   w_dec_base;
  logic [3:0]             w_dec_count;
  logic                   w_dec_valid;
  logic                   w_abort;
  logic                   w_last_word;

  key_slot_decode #(
    .AddrWidth (AddrWidth)
  ) u_decode (
    .target_i     (target_i),
    .slot_i       (slot_i),
    .base_addr_o  (w_dec_base),
    .word_count_o (w_dec_count),
    .valid_o      (w_dec_valid)
  );

  assign w_abort     = abort_i && (r_state != ST_IDLE);
  assign w_last_word = (r_idx == r_count - 4'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    load_gnt_o   = 1'b0;
    busy_o       = (r_state != ST_IDLE);
    done_o       = 1'b0;
    ks_req_o     = 1'b0;
    bus_req_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_gnt_o = load_req_i;
        if (load_req_i && w_dec_valid) w_state_next = ST_READ;
      end
      ST_READ: begin
        ks_req_o     = 1'b1;
        w_state_next = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (ks_rvalid_i) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) w_state_next = w_last_word ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done_o       = !abort_i;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_abort) w_state_next = ST_IDLE;
  end

  // Abort takes priority over any capture or grant in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_req_i) begin
            r_base  <= w_dec_base;
            r_count <= w_dec_count;
            r_index <= ks_index_i;
            r_idx   <= '0;
            r_err   <= !w_dec_valid;
          end
        end
        ST_WAIT_RD: begin
          if (ks_rvalid_i && !abort_i) r_data <= ks_rdata_i;
        end
        ST_WRITE: begin
          if (bus_gnt_i && !abort_i) begin
            r_data <= '0;
            r_idx  <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
      if (w_abort) begin
        r_err  <= 1'b1;
        r_data <= '0;
      end
    end
  end

  assign err_o       = r_err;
  assign ks_addr_o   = r_index + KsAddrWidth'(r_idx);
  assign bus_we_o    = 1'b1;
  assign bus_addr_o  = r_base + (AddrWidth'(r_idx) << 3);
  assign bus_wdata_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_crypto_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_crypto_key_sequencer
// Purpose  : Directed self-checking bench for crypto_key_sequencer.
// Revision : 1.0
// ============================================================================
module tb_crypto_key_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_req_i = 1'b0;
  logic        load_gnt_o;
  logic [1:0]  target_i = 2'd0;
  logic [1:0]  slot_i = 2'd0;
  logic [7:0]  ks_index_i = 8'd0;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        ks_req_o;
  logic [7:0]  ks_addr_o;
  logic        ks_rvalid_i;
  logic [31:0] ks_rdata_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;

  always #5 clk_i = ~clk_i;

  crypto_key_sequencer #(
    .AddrWidth   (64),
    .DataWidth   (32),
    .KsAddrWidth (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_req_i  (load_req_i),
    .load_gnt_o  (load_gnt_o),
    .target_i    (target_i),
    .slot_i      (slot_i),
    .ks_index_i  (ks_index_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .ks_req_o    (ks_req_o),
    .ks_addr_o   (ks_addr_o),
    .ks_rvalid_i (ks_rvalid_i),
    .ks_rdata_i  (ks_rdata_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_gnt_i   (bus_gnt_i)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rd_lat = 1;
  int         bus_req_cycles = 0;
  logic [7:0] ks_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (bus_req_o) bus_req_cycles = bus_req_cycles + 1;

  function automatic logic [31:0] ks_word(input logic [7:0] a);
    return {a ^ 8'h5A, a, 8'hC3, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Key-store model: one read at a time, answered rd_lat cycles after the strobe.
  initial begin
    logic [7:0] a;
    ks_rvalid_i = 1'b0;
    ks_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (ks_req_o) begin
        a = ks_addr_o;
        ks_q.push_back(a);
        @(posedge clk_i);
        repeat (rd_lat - 1) @(posedge clk_i);
        #1;
        ks_rvalid_i = 1'b1;
        ks_rdata_i  = ks_word(a);
        @(posedge clk_i);
        #1;
        ks_rvalid_i = 1'b0;
        ks_rdata_i  = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " load_gnt"}, 64'(load_gnt_o), 64'd0);
    chk({tag, " busy"}, 64'(busy_o), 64'd0);
    chk({tag, " done"}, 64'(done_o), 64'd0);
    chk({tag, " err"}, 64'(err_o), 64'd0);
    chk({tag, " ks_req"}, 64'(ks_req_o), 64'd0);
    chk({tag, " ks_addr"}, 64'(ks_addr_o), 64'd0);
    chk({tag, " bus_req"}, 64'(bus_req_o), 64'd0);
    chk({tag, " bus_addr"}, bus_addr_o, 64'd0);
    chk({tag, " bus_wdata"}, 64'(bus_wdata_o), 64'd0);
    chk({tag, " bus_we"}, 64'(bus_we_o), 64'd1);
  endtask

  task automatic run_load(input logic [1:0] tgt, input logic [1:0] slt, input logic [7:0] idx0,
                          input logic [63:0] exp_base, input int n, input int gnt_dly,
                          input int abort_word, input int exp_lat, input string tag);
    int          c0;
    int          waitc;
    int          done_seen;
    logic [7:0]  e_ks;
    logic [63:0] a0;
    logic [31:0] d0;
    @(posedge clk_i);
    #1;
    load_req_i = 1'b1;
    target_i   = tgt;
    slot_i     = slt;
    ks_index_i = idx0;
    @(negedge clk_i);
    chk({tag, " load_gnt"}, 64'(load_gnt_o), 64'd1);
    c0 = cyc;
    @(posedge clk_i);
    #1;
    load_req_i = 1'b0;
    for (int w = 0; w < n; w++) begin
      e_ks = idx0 + 8'(w);
      waitc = 0;
      @(negedge clk_i);
      while (!bus_req_o && waitc < 50) begin
        @(negedge clk_i);
        waitc = waitc + 1;
      end
      chk({tag, " bus_req seen"}, 64'(bus_req_o), 64'd1);
      if (!bus_req_o) return;
      chk({tag, " bus_addr"}, bus_addr_o, exp_base + 64'(8 * w));
      chk({tag, " bus_wdata"}, 64'(bus_wdata_o), 64'(ks_word(e_ks)));
      if (ks_q.size() == 0) chk({tag, " ks read issued"}, 64'd0, 64'd1);
      else chk({tag, " ks_addr"}, 64'(ks_q.pop_front()), 64'(e_ks));
      if (w == abort_word) begin
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        chk({tag, " err pulse"}, 64'(err_o), 64'd1);
        chk({tag, " bus_req dropped"}, 64'(bus_req_o), 64'd0);
        chk({tag, " busy after abort"}, 64'(busy_o), 64'd0);
        chk({tag, " wdata cleared"}, 64'(bus_wdata_o), 64'd0);
        done_seen = 0;
        repeat (6) begin
          if (done_o) done_seen = done_seen + 1;
          @(negedge clk_i);
        end
        chk({tag, " no done"}, 64'(done_seen), 64'd0);
        chk({tag, " err single pulse"}, 64'(err_o), 64'd0);
        return;
      end
      a0 = bus_addr_o;
      d0 = bus_wdata_o;
      if (gnt_dly > 0) begin
        repeat (gnt_dly) @(negedge clk_i);
        chk({tag, " req held"}, 64'(bus_req_o), 64'd1);
        chk({tag, " addr stable"}, bus_addr_o, a0);
        chk({tag, " data stable"}, 64'(bus_wdata_o), 64'(d0));
      end
      bus_gnt_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus_gnt_i = 1'b0;
    end
    waitc = 0;
    @(negedge clk_i);
    while (!done_o && waitc < 50) begin
      @(negedge clk_i);
      waitc = waitc + 1;
    end
    chk({tag, " done seen"}, 64'(done_o), 64'd1);
    if (exp_lat > 0) chk({tag, " done latency"}, 64'(cyc - c0), 64'(exp_lat));
    @(negedge clk_i);
    chk({tag, " idle after done"}, 64'(busy_o), 64'd0);
    chk({tag, " done one cycle"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int bus_before;
    int seen;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    run_load(2'd0, 2'd1, 8'h10, 64'hfff5_2000_A0, 6, 0, -1, 19, "aes0_s1");
    run_load(2'd1, 2'd2, 8'h30, 64'hfff5_2011_80, 8, 4, -1, 0, "aes1_s2");
    run_load(2'd3, 2'd0, 8'h80, 64'hfff5_2030_D0, 8, 0, -1, 25, "hmac_s0");

    // HMAC slot 1 is unmapped: error pulse, no traffic.
    bus_before = bus_req_cycles;
    @(posedge clk_i);
    #1;
    load_req_i = 1'b1;
    target_i   = 2'd3;
    slot_i     = 2'd1;
    ks_index_i = 8'h44;
    @(negedge clk_i);
    chk("hmac_s1 load_gnt", 64'(load_gnt_o), 64'd1);
    @(posedge clk_i);
    #1;
    load_req_i = 1'b0;
    @(negedge clk_i);
    chk("hmac_s1 err", 64'(err_o), 64'd1);
    chk("hmac_s1 busy", 64'(busy_o), 64'd0);
    repeat (4) @(negedge clk_i);
    chk("hmac_s1 err cleared", 64'(err_o), 64'd0);
    chk("hmac_s1 no ks reads", 64'(ks_q.size()), 64'd0);
    chk("hmac_s1 no bus writes", 64'(bus_req_cycles - bus_before), 64'd0);

    run_load(2'd2, 2'd0, 8'hFE, 64'hfff5_2090_28, 4, 0, -1, 13, "aes2_wrap");
    run_load(2'd0, 2'd0, 8'h20, 64'hfff5_2000_28, 6, 0, 2, 0, "abort");
    run_load(2'd2, 2'd1, 8'h05, 64'hfff5_2090_90, 4, 0, -1, 13, "post_abort");

    // Reset while waiting on a slow key-store read.
    rd_lat = 6;
    @(posedge clk_i);
    #1;
    load_req_i = 1'b1;
    target_i   = 2'd1;
    slot_i     = 2'd0;
    ks_index_i = 8'h40;
    @(posedge clk_i);
    #1;
    load_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_mid busy before", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (busy_o || bus_req_o || ks_req_o) seen = seen + 1;
    end
    chk("rst_mid late rvalid ignored", 64'(seen), 64'd0);
    chk("rst_mid wdata", 64'(bus_wdata_o), 64'd0);
    ks_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
